// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the ASCII command bytes decoded by the mode FSM.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rxState_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    // Command bytes shared with the TX mode FSM
    localparam logic [7:0] CMD_M_UPPER = 8'h4D;
    localparam logic [7:0] CMD_M_LOWER = 8'h6D;
    localparam logic [7:0] CMD_F_UPPER = 8'h46;
    localparam logic [7:0] CMD_F_LOWER = 8'h66;
    localparam logic [7:0] CMD_ONE     = 8'h31;
    localparam logic [7:0] CMD_FIVE    = 8'h35;
    localparam logic [7:0] CMD_ALL     = 8'h41;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on wrap.
// Holding restart keeps the phase at zero so the first tick lands DIV clocks later.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] divCnt;

    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            divCnt <= '0;
        end else if (divCnt == LAST) begin
            divCnt <= '0;
        end else begin
            divCnt <= divCnt + 1'b1;
        end
    end

    assign tick = (divCnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_cmd.sv
// 16x oversampling UART receiver feeding the command/mode FSM (8N1 by default,
// 8E1 with even parity when UART_RX_PARITY_EN is defined).
module uart_rx_cmd
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DIV    = ((CLK_HZ / (BAUD * OVERSAMPLE)) < 1) ? 1 : (CLK_HZ / (BAUD * OVERSAMPLE))
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iRX,
    output logic [7:0] oDATA,
    output logic       oVALID,
    output logic       oFRAME_ERR,
    output logic       oPARITY_ERR,
    output logic       oBUSY
);

    localparam logic [3:0] TICK_EARLY = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] TICK_MID   = 4'(SAMPLE_MID);
    localparam logic [3:0] TICK_LATE  = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] TICK_LAST  = 4'(OVERSAMPLE - 1);

    rxState_t   state;
    logic       rx_p0;
    logic       rx_p1;
    logic [3:0] tickIdx;
    logic [2:0] bitCnt;
    logic [7:0] shiftReg;
    logic       sampEarly;
    logic       sampMid;
    logic       baudTick;
    logic       sTick;
    logic       restartTick;
    logic       maj;
    logic       atResolve;

`ifdef UART_RX_PARITY_EN
    logic       parMismatch;
    logic       parityErr;
    assign oPARITY_ERR = parityErr;
`else
    assign oPARITY_ERR = 1'b0;
`endif

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign restartTick = (state == IDLE);
    assign sTick       = baudTick && (state != IDLE);
    assign maj         = majority3(sampEarly, sampMid, rx_p1);
    assign atResolve   = sTick && (tickIdx == TICK_LATE);
    assign oBUSY       = (state != IDLE);

    uart_baud_tick #(
        .DIV(DIV)
    ) uBaudTick (
        .clk    (clk),
        .reset  (reset),
        .restart(restartTick),
        .tick   (baudTick)
    );

    // Stage p0/p1: two-flop synchronizer, idles high
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= iRX;
            rx_p1 <= rx_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            tickIdx    <= '0;
            bitCnt     <= '0;
            oDATA      <= 8'h00;
            oVALID     <= 1'b0;
            oFRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr   <= 1'b0;
            parMismatch <= 1'b0;
`endif
        end else begin
            oVALID     <= 1'b0;
            oFRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityErr  <= 1'b0;
`endif
            if (sTick) begin
                tickIdx <= tickIdx + 4'd1;
                if (tickIdx == TICK_EARLY) sampEarly <= rx_p1;
                if (tickIdx == TICK_MID)   sampMid   <= rx_p1;
            end

            case (state)
                IDLE: begin
                    tickIdx <= '0;
                    bitCnt  <= '0;
                    if (!rx_p1) state <= START;
                end
                START: begin
                    if (atResolve && maj) begin
                        state <= IDLE;
                    end else if (sTick && tickIdx == TICK_LAST) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (atResolve) shiftReg[bitCnt] <= maj;
                    if (sTick && tickIdx == TICK_LAST) begin
                        if (bitCnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitCnt <= bitCnt + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (atResolve) parMismatch <= (maj != ^shiftReg);
                    if (sTick && tickIdx == TICK_LAST) state <= STOP;
                end
`endif
                // Resolving mid-stop lets a start bit follow immediately
                STOP: begin
                    if (atResolve) begin
                        if (maj) begin
                            oDATA  <= shiftReg;
                            oVALID <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parityErr <= parMismatch;
`endif
                            state  <= IDLE;
                        end else begin
                            oFRAME_ERR <= 1'b1;
                            state      <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_p1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd: directed frames plus random frames against
// a frame-level model (byte, stop bit, parity bit -> expected strobes and timing).
module tb_uart_rx_cmd;
    import uart_pkg::*;

    localparam int CLK_HZ   = 16_000_000;
    localparam int BAUD     = 500_000;
    localparam int DIV      = 2;
    localparam int BIT_CLKS = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Strobe latency counted from the first clock edge that samples the falling line
    localparam int LAT = 2 + (9 * 16 + 10) * DIV + (PAR_EN ? 16 * DIV : 0);

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       v;
        logic       f;
        logic       p;
        logic       busy;
        logic       busyPrev;
    } ev_t;

    logic       clk;
    logic       reset;
    logic       iRX;
    logic [7:0] oDATA;
    logic       oVALID;
    logic       oFRAME_ERR;
    logic       oPARITY_ERR;
    logic       oBUSY;

    int         checks = 0;
    int         errors = 0;
    int         cycleCnt = 0;
    int         lastFall = 0;
    logic       txPar = 1'b0;
    logic [7:0] modelData = 8'h00;
    logic       busyPrev = 1'b0;
    ev_t        monEv;
    ev_t        ev;
    ev_t        evq[$];

    uart_rx_cmd #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iRX        (iRX),
        .oDATA      (oDATA),
        .oVALID     (oVALID),
        .oFRAME_ERR (oFRAME_ERR),
        .oPARITY_ERR(oPARITY_ERR),
        .oBUSY      (oBUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Record every strobe cycle together with the bus state around it
    always @(negedge clk) begin
        if (oVALID || oFRAME_ERR || oPARITY_ERR) begin
            monEv.cyc      = cycleCnt;
            monEv.d        = oDATA;
            monEv.v        = oVALID;
            monEv.f        = oFRAME_ERR;
            monEv.p        = oPARITY_ERR;
            monEv.busy     = oBUSY;
            monEv.busyPrev = busyPrev;
            evq.push_back(monEv);
        end
        busyPrev = oBUSY;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; leaves the line at the stop-bit level
    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        lastFall = cycleCnt;
        iRX = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            iRX = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        iRX = txPar;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        iRX = stopBit;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic checkFrame(input string tag, input logic [7:0] d, input logic stopBit);
        logic expP;
        expP = PAR_EN && (txPar != ^d);
        check({tag, " count"}, 32'(evq.size()), 32'd1);
        if (evq.size() > 0) begin
            ev = evq.pop_front();
            if (stopBit) modelData = d;
            check({tag, " valid"}, 32'(ev.v), 32'(stopBit));
            check({tag, " frameErr"}, 32'(ev.f), 32'(!stopBit));
            check({tag, " parityErr"}, 32'(ev.p), 32'(stopBit && expP));
            check({tag, " data"}, 32'(ev.d), 32'(modelData));
            check({tag, " latency"}, 32'(ev.cyc), 32'(lastFall + 1 + LAT));
            check({tag, " busyAtStrobe"}, 32'(ev.busy), 32'(!stopBit));
            check({tag, " busyBefore"}, 32'(ev.busyPrev), 32'd1);
        end
        evq.delete();
    endtask

    initial begin
        logic [7:0] rd;
        logic       rs;
        int         gap;
        int         fall;

        reset = 1'b0;
        iRX   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst oDATA", 32'(oDATA), 32'h00);
        check("rst oVALID", 32'(oVALID), 32'd0);
        check("rst oFRAME_ERR", 32'(oFRAME_ERR), 32'd0);
        check("rst oPARITY_ERR", 32'(oPARITY_ERR), 32'd0);
        check("rst oBUSY", 32'(oBUSY), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single 'M'
        txPar = ^CMD_M_UPPER;
        sendFrame(CMD_M_UPPER, 1'b1);
        checkFrame("M", CMD_M_UPPER, 1'b1);
        repeat (10) @(negedge clk);

        // 'F' then '5' with no idle gap
        txPar = ^CMD_F_UPPER;
        sendFrame(CMD_F_UPPER, 1'b1);
        checkFrame("F", CMD_F_UPPER, 1'b1);
        txPar = ^CMD_FIVE;
        sendFrame(CMD_FIVE, 1'b1);
        checkFrame("5", CMD_FIVE, 1'b1);
        repeat (10) @(negedge clk);

        // Glitch of 4 ticks: rejected by the start-bit vote
        fall = cycleCnt;
        iRX  = 1'b0;
        repeat (8) @(negedge clk);
        iRX  = 1'b1;
        check("glitch busy", 32'(oBUSY), 32'd1);
        repeat (fall + 3 + 10 * DIV - cycleCnt) @(negedge clk);
        check("glitch idle by tick9", 32'(oBUSY), 32'd0);
        repeat (40) @(negedge clk);
        check("glitch strobes", 32'(evq.size()), 32'd0);
        check("glitch oDATA", 32'(oDATA), 32'(modelData));

        // Bad stop bit followed by a held-low line
        txPar = ^8'hA5;
        sendFrame(8'hA5, 1'b0);
        checkFrame("break", 8'hA5, 1'b0);
        repeat (100 - BIT_CLKS) @(negedge clk);
        check("break busy low", 32'(oBUSY), 32'd1);
        check("break single strobe", 32'(evq.size()), 32'd0);
        iRX = 1'b1;
        repeat (4) @(negedge clk);
        check("break idle", 32'(oBUSY), 32'd0);
        check("break oDATA", 32'(oDATA), 32'(modelData));

        // Reset during data bit 4 of 'A'
        repeat (10) @(negedge clk);
        iRX = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            iRX = CMD_ALL[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        iRX = CMD_ALL[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("midrst busy before", 32'(oBUSY), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        modelData = 8'h00;
        check("midrst busy", 32'(oBUSY), 32'd0);
        check("midrst oDATA", 32'(oDATA), 32'h00);
        reset = 1'b1;
        iRX   = 1'b1;
        repeat (BIT_CLKS * 8) @(negedge clk);
        check("midrst strobes", 32'(evq.size()), 32'd0);
        txPar = ^CMD_ONE;
        sendFrame(CMD_ONE, 1'b1);
        checkFrame("1 after rst", CMD_ONE, 1'b1);
        repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        txPar = 1'b0;
        sendFrame(CMD_M_LOWER, 1'b1);
        checkFrame("m badpar", CMD_M_LOWER, 1'b1);
        txPar = 1'b1;
        sendFrame(CMD_M_LOWER, 1'b1);
        checkFrame("m goodpar", CMD_M_LOWER, 1'b1);
        repeat (10) @(negedge clk);
`endif

        // Random frames: mostly good, some bad stop bits and bad parity
        for (int n = 0; n < 20; n++) begin
            rd    = 8'($urandom_range(0, 255));
            rs    = ($urandom_range(0, 3) != 0);
            txPar = (^rd) ^ ($urandom_range(0, 3) == 0);
            sendFrame(rd, rs);
            checkFrame("rand", rd, rs);
            if (!rs) begin
                repeat ($urandom_range(0, 20)) @(negedge clk);
                iRX = 1'b1;
                gap = $urandom_range(4, 30);
            end else begin
                gap = $urandom_range(0, 30);
            end
            repeat (gap) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("final oDATA", 32'(oDATA), 32'(modelData));
        check("final idle", 32'(oBUSY), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
